// File: rtl/data_mem_master.sv
// Load/store initiator for the data side of the unified memory: sequences the
// combinational read and write strobe, merges sub-word stores and extends loads.
module data_mem_master #(
  parameter logic [31:0] DATA_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_data_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WSETUP = 3'd2,
    WPULSE = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  state_t      state_reg;
  logic        write_reg;
  logic        signed_reg;
  logic [1:0]  size_reg;
  logic [1:0]  lane_reg;
  logic [31:0] wdata_reg;

  logic        accept;
  logic        fault;
  logic [2:0]  nbytes;
  logic [32:0] last_byte;

  assign req_ready = (state_reg == IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    nbytes = 3'd4;
    case (req_size)
      SIZE_BYTE: nbytes = 3'd1;
      SIZE_HALF: nbytes = 3'd2;
      default:   nbytes = 3'd4;
    endcase
  end

  // 33-bit sum so an access running past 0xFFFF_FFFF cannot wrap into range.
  assign last_byte = {1'b0, req_addr} + {30'd0, nbytes} - 33'd1;

  assign fault = (req_size == SIZE_BAD)
               | ((req_size == SIZE_HALF) & req_addr[0])
               | ((req_size == SIZE_WORD) & (|req_addr[1:0]))
               | (last_byte >= {1'b0, DATA_LIMIT});

  function automatic logic [31:0] load_extend(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  lane,
    input logic        sgn
  );
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (size)
      SIZE_BYTE: load_extend = {{24{sgn & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_extend = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default:   load_extend = word;
    endcase
  endfunction

  // Replace only the addressed lane(s); the rest of the sampled word is kept.
  function automatic logic [31:0] store_merge(
    input logic [31:0] word,
    input logic [31:0] wdata,
    input logic [1:0]  size,
    input logic [1:0]  lane
  );
    logic [31:0] lane_mask;
    logic [31:0] mask;
    logic [31:0] ins;
    lane_mask   = (size == SIZE_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
    mask        = lane_mask << {lane, 3'b000};
    ins         = (wdata & lane_mask) << {lane, 3'b000};
    store_merge = (word & ~mask) | ins;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      write_reg     <= 1'b0;
      signed_reg    <= 1'b0;
      size_reg      <= 2'b00;
      lane_reg      <= 2'b00;
      wdata_reg     <= 32'd0;
      mem_data_addr <= 32'd0;
      mem_data_in   <= 32'd0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'd0;
      resp_err      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            write_reg  <= req_write;
            signed_reg <= req_signed;
            size_reg   <= req_size;
            lane_reg   <= req_addr[1:0];
            wdata_reg  <= req_wdata;
            if (fault) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
              state_reg  <= RESP;
            end else begin
              mem_data_addr <= {req_addr[31:2], 2'b00};
              if (!req_write || (req_size != SIZE_WORD)) begin
                mem_read  <= 1'b1;
                state_reg <= RD;
              end else begin
                mem_data_in <= req_wdata;
                state_reg   <= WSETUP;
              end
            end
          end
        end

        RD: begin
          mem_read <= 1'b0;
          if (!write_reg) begin
            resp_rdata <= load_extend(mem_data_out, size_reg, lane_reg, signed_reg);
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state_reg  <= RESP;
          end else begin
            mem_data_in <= store_merge(mem_data_out, wdata_reg, size_reg, lane_reg);
            state_reg   <= WSETUP;
          end
        end

        // Address and data have been stable for a full cycle before the strobe rises.
        WSETUP: begin
          mem_write <= 1'b1;
          state_reg <= WPULSE;
        end

        WPULSE: begin
          mem_write  <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
          state_reg  <= RESP;
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            state_reg  <= IDLE;
          end
        end

        default: begin
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          resp_valid <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

endmodule
